stream_to_bram_writer: RTL and testbench
========================================

// Module: stream_to_bram_writer
// PURPOSE
//  Upstream master for the BRAM AXI-lite slave. Buffers a valid/ready word stream in a small FIFO.
//  On a start command, writes LEN words to sequential word addresses through the slave's AW/W/B channels.
//  One write is outstanding at a time; completion and error status go to the controller.
// PARAMETERS
//  ADDR_WIDTH  10  word-address width; matches the slave's address port
//  DATA_WIDTH  32  data width; multiple of 8
//  FIFO_DEPTH  4   input FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1             clock; all logic on posedge
//  rst          in   1             asynchronous, active-high reset
//  s_data       in   DATA_WIDTH    input stream word
//  s_valid      in   1             input word valid
//  s_ready      out  1             FIFO can accept (= !full)
//  start        in   1             1-cycle command pulse
//  start_addr   in   ADDR_WIDTH    first word address
//  len          in   ADDR_WIDTH+1  words to write, 0..2**ADDR_WIDTH
//  busy         out  1             command in progress
//  done         out  1             1-cycle pulse at command end
//  err          out  1             sticky: some b_response!=0 this command
//  words_done   out  ADDR_WIDTH+1  B responses received this command
//  axi_awaddr   out  ADDR_WIDTH    write address
//  axi_awvalid  out  1             write address valid
//  axi_awready  in   1             slave accepts address
//  axi_wdata    out  DATA_WIDTH    write data
//  axi_wstrb    out  DATA_WIDTH/8  constant all-ones
//  axi_wvalid   out  1             write data valid
//  axi_wready   in   1             slave accepts data
//  b_valid      in   1             write response valid
//  b_ready      out  1             response accept
//  b_response   in   2             00 = OKAY; anything else sets err
// BEHAVIOUR
//  Reset (async, immediate): all valids, b_ready, busy, done, err = 0; words_done = 0; s_ready = 0 while rst is high.
//   Reset flushes the FIFO and returns the FSM to IDLE.
//   A write interrupted by reset is abandoned; the slave is reset on the same rst.
//  FIFO: push on s_valid&&s_ready; pop in FETCH when not empty.
//   Push and pop in the same cycle leave the count unchanged. s_ready is low only when full.
//   The FIFO fills in any state, including IDLE.
//  FSM: IDLE -> FETCH -> XFER -> RESP -> (FETCH | DONE) -> IDLE.
//   IDLE: on start, latch addr=start_addr, rem=len, clear err and words_done, set busy.
//    If len==0, go to DONE (no AXI traffic). Otherwise go to FETCH. start is ignored while busy.
//   FETCH: wait while the FIFO is empty. On pop, register wdata and awaddr=addr.
//    Assert axi_awvalid and axi_wvalid together on the next cycle and enter XFER.
//   XFER: each valid holds until its own valid&&ready on a posedge, then drops independently.
//    awaddr and wdata stay stable while either valid is high.
//    When both handshakes are done (same or different cycles), raise b_ready and enter RESP.
//   RESP: on b_valid&&b_ready: drop b_ready, words_done+1, addr+1 (wraps 2**ADDR_WIDTH-1 -> 0), rem-1.
//    If b_response!=0, set err. The command continues regardless of err.
//    If rem becomes 0, go to DONE; otherwise go to FETCH.
//   DONE: done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
//    words_done and err hold until the next start.
//  Latency with the FIFO non-empty: start sampled at cycle T.
//   FETCH at T+1; awvalid/wvalid high at T+2.
//   Throughput is bounded by the slave's per-write turnaround, one write at a time.
//  A ready asserted without a matching valid has no effect.
// TESTING
//  1 Preload 4 words A0..A3 then start(addr=5, len=4) -> mem[5..8]=A0..A3, words_done=4, one done pulse, err=0.
//  2 start(addr=1023, len=3), data 11,22,33 -> mem[1023]=11, mem[0]=22, mem[1]=33 (wrap).
//  3 start(len=0) -> done 2 cycles after start, no awvalid ever, busy high for 1 cycle.
//  4 Hold awready 0 for 3 cycles while wready=1 -> wvalid drops after its own handshake.
//    awvalid/awaddr stay stable until accepted; exactly one write occurs.
//  5 Force b_response=2'b10 on word 2 of 4 -> all 4 writes happen; err=1 at done; cleared by next start.
//  6 Assert rst mid-XFER with FIFO holding 3 words -> valids/busy 0 at once.
//    After release: s_ready=1, FIFO empty, new start works.

Source files
------------

// File: rtl/stream_to_bram_writer.sv
// Buffers a valid/ready word stream in a small FIFO and, per start command, writes LEN words
// to sequential word addresses of an AXI-lite BRAM slave with a single write outstanding.
module stream_to_bram_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   start_addr,
    input  logic [ADDR_WIDTH:0]     len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH:0]     words_done,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [1:0]              b_response
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]      FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]      CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE    = PTR_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] LEN_ONE    = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_XFER, S_RESP, S_FIN} state_t;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   rem;
    logic                  aw_ok;
    logic                  w_ok;
    logic                  b_hs;

    assign s_ready    = !rst && (count != FULL_COUNT);
    assign fifo_empty = (count == '0);
    assign push       = s_valid && s_ready;
    assign pop        = (state == S_FETCH) && !fifo_empty;
    assign axi_wstrb  = '1;
    // A channel counts as finished once its valid has dropped or is being accepted now.
    assign aw_ok      = !axi_awvalid || axi_awready;
    assign w_ok       = !axi_wvalid || axi_wready;
    assign b_hs       = b_valid && b_ready;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (len == '0) ? S_FIN : S_FETCH;
            S_FETCH: if (!fifo_empty) state_next = S_XFER;
            S_XFER:  if (aw_ok && w_ok) state_next = S_RESP;
            S_RESP:  if (b_hs) state_next = (rem == LEN_ONE) ? S_FIN : S_FETCH;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            b_ready     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            words_done  <= '0;
            rem         <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        rem        <= len;
                        err        <= 1'b0;
                        words_done <= '0;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) begin
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                    end
                end
                S_XFER: begin
                    if (axi_awready) axi_awvalid <= 1'b0;
                    if (axi_wready)  axi_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) b_ready <= 1'b1;
                end
                S_RESP: begin
                    if (b_hs) begin
                        b_ready    <= 1'b0;
                        words_done <= words_done + LEN_ONE;
                        rem        <= rem - LEN_ONE;
                        if (b_response != 2'b00) err <= 1'b1;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Address and data registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) addr <= start_addr;
        else if (state == S_RESP && b_hs) addr <= addr + ADDR_ONE;
        if (pop) begin
            axi_awaddr <= addr;
            axi_wdata  <= fifo_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_stream_to_bram_writer.sv
// Self-checking bench for stream_to_bram_writer: directed corner cases and randomized commands
// checked against a BRAM slave model and a per-address reference array.
module tb_stream_to_bram_writer;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_done;
    logic [AW-1:0] axi_awaddr;
    logic          axi_awvalid;
    logic          axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic          axi_wvalid;
    logic          axi_wready;
    logic          b_valid;
    logic          b_ready;
    logic [1:0]    b_response;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    stream_to_bram_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .start(start), .start_addr(start_addr), .len(len),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .b_valid(b_valid), .b_ready(b_ready), .b_response(b_response)
    );

    // Slave model: captures AW and W independently, writes memory, then returns one B.
    logic [DW-1:0] mem [1024];
    logic          aw_got = 1'b0;
    logic          w_got = 1'b0;
    logic [AW-1:0] aw_a;
    logic [DW-1:0] w_d;
    int            aw_hs_cnt = 0;
    int            w_hs_cnt = 0;
    int            wr_total = 0;
    int            bad_global = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            b_valid    <= 1'b0;
            b_response <= 2'b00;
        end else begin
            if (axi_awvalid && axi_awready) begin
                aw_hs_cnt <= aw_hs_cnt + 1;
                if (!aw_got) begin
                    aw_got <= 1'b1;
                    aw_a   <= axi_awaddr;
                end
            end
            if (axi_wvalid && axi_wready) begin
                w_hs_cnt <= w_hs_cnt + 1;
                if (!w_got) begin
                    w_got <= 1'b1;
                    w_d   <= axi_wdata;
                end
            end
            if (aw_got && w_got && !b_valid) begin
                mem[aw_a]  <= w_d;
                b_valid    <= 1'b1;
                b_response <= (wr_total == bad_global) ? 2'b10 : 2'b00;
                wr_total   <= wr_total + 1;
                aw_got     <= 1'b0;
                w_got      <= 1'b0;
            end
            if (b_valid && b_ready) b_valid <= 1'b0;
        end
    end

    // Ready generators: 0 = always ready, 1 = random, 2 = held low.
    int aw_mode = 0;
    int w_mode = 0;
    always begin
        @(posedge clk);
        #2;
        axi_awready = (aw_mode == 2) ? 1'b0 : (aw_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        axi_wready  = (w_mode == 2)  ? 1'b0 : (w_mode == 1)  ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Stream source: offers the queue head; a word leaves the queue when accepted at the next posedge.
    logic [DW-1:0] feed_q [$];
    bit            feed_gaps = 1'b0;
    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(negedge clk);
            if (feed_q.size() > 0 && (!feed_gaps || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_data  = feed_q[0];
                if (s_ready) void'(feed_q.pop_front());
            end else begin
                s_valid = 1'b0;
            end
        end
    end

    int done_cnt = 0;
    int awv_cycles = 0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (axi_awvalid) awv_cycles <= awv_cycles + 1;
    end

    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] cmd_words [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int waited);
        waited = 0;
        while (!done && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic wait_fifo_loaded();
        for (int i = 0; i < 100 && feed_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input int n, input int bad_idx,
                           input bit preloaded, input string tag);
        int base_aw, base_w, base_done, base_awv, waited, bad_words;
        logic [AW-1:0] ai;
        bit exp_err;
        exp_err   = (bad_idx < n);
        base_aw   = aw_hs_cnt;
        base_w    = w_hs_cnt;
        base_done = done_cnt;
        base_awv  = awv_cycles;
        bad_global = wr_total + bad_idx;
        for (int i = 0; i < n; i++) begin
            ai = a + AW'(i);
            ref_mem[ai] = cmd_words[i];
            if (!preloaded) feed_q.push_back(cmd_words[i]);
        end
        @(negedge clk);
        start = 1'b1;
        start_addr = a;
        len = (AW+1)'(n);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(busy), 64'(1));
        check({tag, "_err_cleared"}, 64'(err), 64'(0));
        check({tag, "_words_done_cleared"}, 64'(words_done), 64'(0));
        if (preloaded && n > 0) begin
            check({tag, "_awvalid_t1"}, 64'(axi_awvalid), 64'(0));
            @(negedge clk);
            check({tag, "_awvalid_t2"}, 64'(axi_awvalid), 64'(1));
            check({tag, "_wvalid_t2"}, 64'(axi_wvalid), 64'(1));
            check({tag, "_awaddr_first"}, 64'(axi_awaddr), 64'(a));
            check({tag, "_wdata_first"}, 64'(axi_wdata), 64'(cmd_words[0]));
        end
        wait_done(tag, waited);
        if (n == 0) check({tag, "_done_latency"}, 64'(waited), 64'(1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'(0));
        check({tag, "_words_done"}, 64'(words_done), 64'(n));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 64'(done), 64'(0));
        check({tag, "_err_held"}, 64'(err), 64'(exp_err));
        check({tag, "_done_pulses"}, 64'(done_cnt - base_done), 64'(1));
        check({tag, "_aw_handshakes"}, 64'(aw_hs_cnt - base_aw), 64'(n));
        check({tag, "_w_handshakes"}, 64'(w_hs_cnt - base_w), 64'(n));
        if (n == 0) check({tag, "_no_awvalid"}, 64'(awv_cycles - base_awv), 64'(0));
        bad_words = 0;
        for (int i = 0; i < n; i++) begin
            ai = a + AW'(i);
            if (mem[ai] !== ref_mem[ai]) bad_words++;
        end
        check({tag, "_mem_words_wrong"}, 64'(bad_words), 64'(0));
        bad_global = -1;
    endtask

    initial begin
        int waited, base_aw, base_w, base_awv, n;
        logic [DW-1:0] word, old_word;

        rst = 1'b1;
        start = 1'b0;
        start_addr = '0;
        len = '0;
        axi_awready = 1'b0;
        axi_wready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_awvalid", 64'(axi_awvalid), 64'(0));
        check("rst_wvalid", 64'(axi_wvalid), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_words_done", 64'(words_done), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("s_ready_after_rst", 64'(s_ready), 64'(1));
        check("wstrb_all_ones", 64'(axi_wstrb), 64'(4'hF));

        // Preloaded FIFO, latency and basic burst
        cmd_words.delete();
        for (int i = 0; i < 4; i++) cmd_words.push_back($urandom);
        for (int i = 0; i < 4; i++) feed_q.push_back(cmd_words[i]);
        wait_fifo_loaded();
        check("fifo_full_s_ready", 64'(s_ready), 64'(0));
        run_cmd(10'd5, 4, 100, 1'b1, "t1");

        // Address wrap
        cmd_words.delete();
        cmd_words.push_back(32'h11);
        cmd_words.push_back(32'h22);
        cmd_words.push_back(32'h33);
        run_cmd(10'd1023, 3, 100, 1'b0, "t2");
        check("t2_mem0", 64'(mem[0]), 64'(32'h22));
        check("t2_mem1023", 64'(mem[1023]), 64'(32'h11));

        // Zero-length command
        cmd_words.delete();
        run_cmd(10'd42, 0, 100, 1'b0, "t3");

        // Address channel stalled while data is accepted
        aw_mode = 2;
        w_mode = 0;
        word = $urandom;
        feed_q.push_back(word);
        base_aw = aw_hs_cnt;
        base_w = w_hs_cnt;
        @(negedge clk);
        start = 1'b1;
        start_addr = 10'd300;
        len = 11'd1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!axi_awvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("t4_awvalid_seen", 64'(axi_awvalid), 64'(1));
        check("t4_wvalid_first", 64'(axi_wvalid), 64'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_awvalid_held", 64'(axi_awvalid), 64'(1));
            check("t4_awaddr_stable", 64'(axi_awaddr), 64'(10'd300));
            check("t4_wvalid_dropped", 64'(axi_wvalid), 64'(0));
        end
        aw_mode = 0;
        wait_done("t4", waited);
        @(negedge clk);
        check("t4_aw_handshakes", 64'(aw_hs_cnt - base_aw), 64'(1));
        check("t4_w_handshakes", 64'(w_hs_cnt - base_w), 64'(1));
        check("t4_mem", 64'(mem[300]), 64'(word));

        // Error response on the second of four writes
        cmd_words.delete();
        for (int i = 0; i < 4; i++) cmd_words.push_back($urandom);
        run_cmd(10'd600, 4, 1, 1'b0, "t5");

        // Randomized commands with random readiness and stream gaps
        aw_mode = 1;
        w_mode = 1;
        feed_gaps = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(1, 12));
            cmd_words.delete();
            for (int i = 0; i < n; i++) cmd_words.push_back($urandom);
            run_cmd(AW'($urandom_range(0, 1023)), n, int'($urandom_range(0, 2 * n)), 1'b0, "rnd");
        end

        // Reset in the middle of a transfer with the FIFO partly full
        aw_mode = 2;
        w_mode = 0;
        feed_gaps = 1'b0;
        for (int i = 0; i < 4; i++) feed_q.push_back($urandom);
        wait_fifo_loaded();
        check("t6_fifo_full", 64'(s_ready), 64'(0));
        old_word = mem[100];
        base_aw = aw_hs_cnt;
        @(negedge clk);
        start = 1'b1;
        start_addr = 10'd100;
        len = 11'd2;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (!axi_awvalid && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("t6_in_xfer", 64'(axi_awvalid), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("t6_rst_awvalid", 64'(axi_awvalid), 64'(0));
        check("t6_rst_wvalid", 64'(axi_wvalid), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_b_ready", 64'(b_ready), 64'(0));
        check("t6_rst_s_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("t6_s_ready_after", 64'(s_ready), 64'(1));
        check("t6_no_aw_handshake", 64'(aw_hs_cnt - base_aw), 64'(0));
        check("t6_mem_untouched", 64'(mem[100]), 64'(old_word));
        aw_mode = 0;
        @(negedge clk);
        start = 1'b1;
        start_addr = 10'd200;
        len = 11'd1;
        @(negedge clk);
        start = 1'b0;
        base_awv = awv_cycles;
        repeat (6) @(negedge clk);
        check("t6_fifo_empty_no_awvalid", 64'(awv_cycles - base_awv), 64'(0));
        check("t6_busy_waiting", 64'(busy), 64'(1));
        word = $urandom;
        feed_q.push_back(word);
        wait_done("t6", waited);
        check("t6_words_done", 64'(words_done), 64'(1));
        @(negedge clk);
        check("t6_mem_new", 64'(mem[200]), 64'(word));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
